// File: rtl/enemy_rom_arbiter_if.sv
// enemy_rom_arbiter_if: requester/ROM/response bundle between enemy draw units and the sprite ROM arbiter
interface enemy_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [2*NUM_REQ-1:0] req_dir;
   logic [2*NUM_REQ-1:0] req_step;
   logic [6*NUM_REQ-1:0] req_x;
   logic [6*NUM_REQ-1:0] req_y;
   logic [NUM_REQ-1:0]   gnt;
   logic [15:0]          rom_addr;
   logic [4:0]           rom_data;
   logic                 rd_valid;
   logic [ID_W-1:0]      rd_id;
   logic [4:0]           rd_data;

   modport master (
      output req, req_dir, req_step, req_x, req_y, rom_data,
      input  gnt, rom_addr, rd_valid, rd_id, rd_data
   );

   modport slave (
      input  req, req_dir, req_step, req_x, req_y, rom_data,
      output gnt, rom_addr, rd_valid, rd_id, rd_data
   );
endinterface

// File: rtl/enemy_rom_arbiter.sv
// enemy_rom_arbiter: round-robin share of the 1-cycle-latency sprite ROM among enemy draw units,
// returning one tagged palette index per grant with fixed two-edge latency.
module enemy_rom_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter int         ID_W        = 2,
   parameter int         SPR_W       = 40,
   parameter int         SPR_H       = 64,
   parameter int         FRAME_SZ    = 2560,
   parameter logic [4:0] TRANSPARENT = 5'h00
) (
   input logic              i_clk,
   input logic              i_rst,
   enemy_rom_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ID_W-1:0]    r_ptr, w_win, w_nxt;
   logic               w_any, w_oor;
   int                 w_idx;
   logic [1:0]         w_dir, w_step;
   logic [5:0]         w_x, w_y;
   logic [15:0]        w_addr;
   logic [NUM_REQ-1:0] r_gnt;
   logic [15:0]        r_addr;
   logic               r_s1_v, r_s1_tr, r_s2_v, r_s2_tr, r_rd_v;
   logic [ID_W-1:0]    r_s1_id, r_s2_id, r_rd_id;
   logic [4:0]         r_rd_data;

   // first asserted request at or after the pointer, wrapping
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_any && bus.req[IW'(w_idx)]) begin
            w_any = 1'b1;
            w_win = ID_W'(w_idx);
         end
      end
   end

   always_comb begin
      w_dir  = 2'(bus.req_dir  >> (2 * int'(w_win)));
      w_step = 2'(bus.req_step >> (2 * int'(w_win)));
      w_x    = 6'(bus.req_x    >> (6 * int'(w_win)));
      w_y    = 6'(bus.req_y    >> (6 * int'(w_win)));
      w_addr = (16'(w_dir) * 16'd3 + 16'(w_step)) * 16'(FRAME_SZ)
             + 16'(w_y) * 16'(SPR_W) + 16'(w_x);
      w_oor  = (w_step == 2'd3) || (int'(w_x) >= SPR_W) || (int'(w_y) >= SPR_H);
      w_nxt  = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_addr    <= '0;
         r_s1_v    <= 1'b0;
         r_s1_tr   <= 1'b0;
         r_s1_id   <= '0;
         r_s2_v    <= 1'b0;
         r_s2_tr   <= 1'b0;
         r_s2_id   <= '0;
         r_rd_v    <= 1'b0;
         r_rd_id   <= '0;
         r_rd_data <= '0;
      end else begin
         r_gnt   <= w_any ? NUM_REQ'(1) << w_win : '0;
         r_s1_v  <= w_any;
         r_s1_id <= w_win;
         r_s1_tr <= w_oor;
         if (w_any) begin
            r_ptr  <= w_nxt;
            r_addr <= w_oor ? 16'd0 : w_addr;
         end
         // stage 2 lines up with the ROM's registered data
         r_s2_v  <= r_s1_v;
         r_s2_id <= r_s1_id;
         r_s2_tr <= r_s1_tr;
         r_rd_v  <= r_s2_v;
         if (r_s2_v) begin
            r_rd_id   <= r_s2_id;
            r_rd_data <= r_s2_tr ? TRANSPARENT : bus.rom_data;
         end
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.rom_addr = r_addr;
   assign bus.rd_valid = r_rd_v;
   assign bus.rd_id    = r_rd_id;
   assign bus.rd_data  = r_rd_data;
endmodule
